// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader_if
// Brief    : Byte-stream receive and instruction-memory write signals of the loader
// Revision : 1.0
// ============================================================================
interface instr_loader_if #(
  parameter int ADDR_W = 9
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // master: byte source / memory observer; slave: the loader itself
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Brief    : Streams a length-prefixed byte image into instruction memory and
//            releases cpu_hold on success. INSTR_LOADER_CHECKSUM_EN adds an
//            XOR trailer byte check.
// Revision : 1.0
// ============================================================================
module instr_loader #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_loader_if.slave     bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   words_loaded
);

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;
`endif

  localparam logic [15:0]       c_depth     = 16'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_one_a     = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_one_w     = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [7:0]        r_cnt_lo;
  logic [ADDR_W:0]   r_last;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_buf;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_accept;
  logic [15:0]       w_count;

  assign w_accept = bus.rx_valid & bus.rx_ready;
  assign w_count  = {bus.rx_data, r_cnt_lo};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt_lo      <= 8'h00;
      r_last        <= '0;
      r_byte_idx    <= 2'd0;
      r_buf         <= 24'h0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_csum        <= 8'h00;
`endif
      bus.rx_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'h0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      cpu_hold      <= 1'b1;
      words_loaded  <= '0;
    end else begin
      // Write strobe lasts one cycle; the address saturates on the final word.
      if (bus.mem_we) begin
        bus.mem_we   <= 1'b0;
        words_loaded <= words_loaded + c_one_w;
        if (bus.mem_addr != c_last_addr)
          bus.mem_addr <= bus.mem_addr + c_one_a;
      end

      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state      <= S_HDR0;
            bus.rx_ready <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_hold     <= 1'b1;
            words_loaded <= '0;
            bus.mem_addr <= '0;
            r_byte_idx   <= 2'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum       <= 8'h00;
`endif
          end
        end

        S_HDR0: begin
          if (w_accept) begin
            r_cnt_lo <= bus.rx_data;
            r_state  <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (w_accept) begin
            r_last <= (ADDR_W+1)'(w_count - 16'd1);
            if (w_count == 16'd0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
              r_state      <= S_CSUM;
`else
              r_state      <= S_DONE;
              bus.rx_ready <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              cpu_hold     <= 1'b0;
`endif
            end else if (w_count > c_depth) begin
              r_state      <= S_ERROR;
              bus.rx_ready <= 1'b0;
              busy         <= 1'b0;
              err          <= 1'b1;
            end else begin
              r_state      <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ bus.rx_data;
`endif
            case (r_byte_idx)
              2'd0: r_buf[7:0]   <= bus.rx_data;
              2'd1: r_buf[15:8]  <= bus.rx_data;
              2'd2: r_buf[23:16] <= bus.rx_data;
              default: begin
                bus.mem_we    <= 1'b1;
                bus.mem_wdata <= {bus.rx_data, r_buf};
                // words_loaded still holds this word's index here
                if (words_loaded == r_last) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  r_state      <= S_CSUM;
`else
                  r_state      <= S_DONE;
                  bus.rx_ready <= 1'b0;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  cpu_hold     <= 1'b0;
`endif
                end
              end
            endcase
          end
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_accept) begin
            bus.rx_ready <= 1'b0;
            busy         <= 1'b0;
            if (bus.rx_data == r_csum) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              r_state  <= S_ERROR;
              err      <= 1'b1;
            end
          end
        end
`endif

        default: begin
          r_state      <= S_IDLE;
          bus.rx_ready <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_loader
// Brief    : Directed loads checked against a word-level write/outcome model
// Revision : 1.0
// ============================================================================
module tb_instr_loader;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;
  logic [ADDR_W:0]   words_loaded;

  int                tests;
  int                fails;
  wr_t               exp_q[$];
  logic [31:0]       tb_mem [DEPTH];

  instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .cpu_hold     (cpu_hold),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every write strobe must match the next word the model predicted.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we === 1'b1) begin
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("write_data", bus.mem_wdata, e.data);
        tb_mem[bus.mem_addr] = bus.mem_wdata;
      end
    end
  end

  task automatic do_start(input bit collide);
    @(negedge clk);
    start        = 1'b1;
    bus.rx_valid = collide;
    bus.rx_data  = 8'hEE;
    @(posedge clk);
    @(negedge clk);
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    check("start_ready", 32'(bus.rx_ready), 32'd1);
    check("start_busy",  32'(busy), 32'd1);
    check("start_done",  32'(done), 32'd0);
  endtask

  task automatic send(input logic [7:0] b[$], input bit gaps);
    int  i;
    int  guard;
    bit  v;
    logic rdy;
    i = 0;
    guard = 0;
    while (i < b.size()) begin
      @(negedge clk);
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rx_valid = v;
      bus.rx_data  = b[i];
      rdy = bus.rx_ready;
      @(posedge clk);
      if (v && rdy) i++;
      guard++;
      if (guard > 20000) begin
        check("send_progress", 32'(i), 32'(b.size()));
        break;
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Model: count words of 4 LE bytes at addresses 0..count-1, or an error
  // straight after the header when count exceeds DEPTH.
  task automatic run_load(input string nm, input int cnt, input logic [7:0] data[$],
                          input bit gaps, input bit bad_csum, input bit collide);
    logic [7:0] s[$];
    logic [7:0] x;
    bit         exp_err;
    int         nw;
    int         exp_addr;
    exp_err = (cnt > DEPTH);
    nw      = exp_err ? 0 : cnt;
    for (int w = 0; w < nw; w++)
      exp_q.push_back('{addr: ADDR_W'(w),
                        data: {data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]}});
    s.push_back(8'(cnt));
    s.push_back(8'(cnt >> 8));
    if (!exp_err) begin
      x = 8'h00;
      for (int k = 0; k < 4*nw; k++) begin
        s.push_back(data[k]);
        x ^= data[k];
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      s.push_back(bad_csum ? (x ^ 8'h01) : x);
      exp_err = bad_csum;
`endif
    end
    do_start(collide);
    send(s, gaps);
    check({nm, "_done"},     32'(done),     32'(!exp_err));
    check({nm, "_err"},      32'(err),      32'(exp_err));
    check({nm, "_cpu_hold"}, 32'(cpu_hold), 32'(exp_err));
    check({nm, "_busy"},     32'(busy),     32'd0);
    @(negedge clk);
    exp_addr = (nw == 0) ? 0 : ((nw == DEPTH) ? DEPTH - 1 : nw);
    check({nm, "_words"},    32'(words_loaded), 32'(nw));
    check({nm, "_addr"},     32'(bus.mem_addr), 32'(exp_addr));
    check({nm, "_pending"},  32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d[$];
    logic [7:0] empty_q[$];
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_mem_we",   32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata",    bus.mem_wdata, 32'd0);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_err",      32'(err), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_words",    32'(words_loaded), 32'd0);
    rst_n = 1'b1;

    // Two words back-to-back; the byte offered with start must be ignored.
    d = {8'hB7, 8'h00, 8'hA0, 8'h00, 8'hD7, 8'h00, 8'h30, 8'h00};
    run_load("two", 2, d, 1'b0, 1'b0, 1'b1);
    check("two_word0", tb_mem[0], 32'h00A000B7);
    check("two_word1", tb_mem[1], 32'h003000D7);

    run_load("oversize", 513, empty_q, 1'b0, 1'b0, 1'b0);

    run_load("zero", 0, empty_q, 1'b0, 1'b0, 1'b0);

    d.delete();
    for (int w = 0; w < DEPTH; w++) begin
      logic [31:0] v;
      v = 32'hC0DE0000 | 32'(w);
      d.push_back(v[7:0]);
      d.push_back(v[15:8]);
      d.push_back(v[23:16]);
      d.push_back(v[31:24]);
    end
    run_load("full", DEPTH, d, 1'b0, 1'b0, 1'b0);
    check("full_last_word", tb_mem[DEPTH-1], 32'hC0DE01FF);
    check("full_first_word", tb_mem[0], 32'hC0DE0000);

    d = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h23, 8'h45, 8'h67,
         8'h89, 8'hAB, 8'hCD, 8'hEF};
    run_load("gaps", 3, d, 1'b1, 1'b0, 1'b0);
    check("gaps_word0", tb_mem[0], 32'hDDCCBBAA);
    check("gaps_word2", tb_mem[2], 32'hEFCDAB89);

    // Reset after six data bytes: only word 0 lands.
    exp_q.push_back('{addr: ADDR_W'(0), data: 32'h04030201});
    do_start(1'b0);
    d = {8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(d, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy",     32'(busy), 32'd0);
    check("midrst_ready",    32'(bus.rx_ready), 32'd0);
    check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("midrst_words",    32'(words_loaded), 32'd0);
    check("midrst_pending",  32'(exp_q.size()), 32'd0);
    check("midrst_word0",    tb_mem[0], 32'h04030201);
    exp_q.delete();
    rst_n = 1'b1;
    d = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    run_load("reload", 2, d, 1'b0, 1'b0, 1'b0);
    check("reload_word0", tb_mem[0], 32'h13121110);

`ifdef INSTR_LOADER_CHECKSUM_EN
    d = {8'h11, 8'h22, 8'h33, 8'h44};
    run_load("csum_ok", 1, d, 1'b0, 1'b0, 1'b0);
    tb_mem[0] = 32'h0;
    run_load("csum_bad", 1, d, 1'b0, 1'b1, 1'b0);
    check("csum_bad_word0", tb_mem[0], 32'h44332211);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
